// File: rtl/ifetch.sv
// Instruction fetch stage.
// Holds the PC, issues in-order word fetches over a req/gnt + rvalid interface,
// buffers up to DEPTH {pc,instr} pairs and presents them to decode over
// valid/ready. Accepted control-flow redirects flush the wrong path. Responses
// that were already in flight for that path are counted in drop_cnt and
// discarded when they arrive.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   f_imem_req_o / f_imem_addr_o    fetch request and word address (= pc_q)
//   f_imem_gnt_i                    request accepted this cycle
//   f_imem_rvalid_i/f_imem_rdata_i  in-order response
//   f_valid_o / f_ready_i           head-entry handshake with decode
//   f_instr_o / f_pc_o              head instruction and pc (NOP / 0 when idle)
//   d_branch_i, d_jump_jal_i, d_jump_jalr_i and d_pc_*_i
//                                   redirect requests and targets from decode
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        f_imem_req_o,
    output logic [63:0] f_imem_addr_o,
    input  logic        f_imem_gnt_i,
    input  logic        f_imem_rvalid_i,
    input  logic [31:0] f_imem_rdata_i,
    output logic        f_valid_o,
    input  logic        f_ready_i,
    output logic [31:0] f_instr_o,
    output logic [63:0] f_pc_o,
    input  logic        d_branch_i,
    input  logic [63:0] d_pc_b_i,
    input  logic        d_jump_jal_i,
    input  logic [63:0] d_pc_jal_i,
    input  logic        d_jump_jalr_i,
    input  logic [63:0] d_pc_jalr_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [63:0] pc_q, pc_d;
    cnt_t        wr_ptr_q, wr_ptr_d;
    cnt_t        fill_ptr_q, fill_ptr_d;
    cnt_t        rd_ptr_q, rd_ptr_d;
    cnt_t        drop_cnt_q, drop_cnt_d;

    logic [63:0] buf_pc_q    [DEPTH];
    logic [31:0] buf_instr_q [DEPTH];

    cnt_t        alloc_cnt;
    cnt_t        unfilled_cnt;
    cnt_t        filled_cnt;
    logic [CW:0] occupied;
    logic        head_valid;
    logic        pop;
    logic        redirect;
    logic        alloc;
    logic        drop_rsp;
    logic        fill_rsp;
    logic [63:0] target;

    logic [PW-1:0] wr_idx, fill_idx, rd_idx;

    assign wr_idx   = wr_ptr_q[PW-1:0];
    assign fill_idx = fill_ptr_q[PW-1:0];
    assign rd_idx   = rd_ptr_q[PW-1:0];

    // All occupancy figures come from registered state only, so a pop does not
    // make room for a request in the same cycle.
    assign alloc_cnt    = wr_ptr_q - rd_ptr_q;
    assign unfilled_cnt = wr_ptr_q - fill_ptr_q;
    assign filled_cnt   = fill_ptr_q - rd_ptr_q;
    // Responses still owed for flushed entries also hold a slot.
    assign occupied     = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};

    assign head_valid = (filled_cnt != '0);
    assign pop        = head_valid & f_ready_i;
    assign redirect   = pop & (d_branch_i | d_jump_jal_i | d_jump_jalr_i);

    assign f_imem_req_o  = ~rst & (occupied < DEPTH_W) & ~redirect;
    assign f_imem_addr_o = pc_q;
    assign alloc         = f_imem_req_o & f_imem_gnt_i;

    assign drop_rsp = f_imem_rvalid_i & (drop_cnt_q != '0);
    // A response with nothing outstanding and nothing to drop is ignored.
    assign fill_rsp = f_imem_rvalid_i & (drop_cnt_q == '0) & (unfilled_cnt != '0);

    always_comb begin
        target = d_pc_b_i;
        if (d_jump_jalr_i) begin
            target = d_pc_jalr_i;
        end else if (d_jump_jal_i) begin
            target = d_pc_jal_i;
        end
        target[1:0] = 2'b00;
    end

    always_comb begin
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q + cnt_t'(alloc);
        fill_ptr_d = fill_ptr_q + cnt_t'(fill_rsp);
        rd_ptr_d   = rd_ptr_q + cnt_t'(pop);
        drop_cnt_d = drop_cnt_q - cnt_t'(drop_rsp);

        if (redirect) begin
            pc_d       = target;
            // Everything behind the control instruction is wrong-path; any of it
            // still waiting on memory must be discarded on arrival.
            drop_cnt_d = drop_cnt_q - cnt_t'(drop_rsp)
                         + (unfilled_cnt - cnt_t'(fill_rsp));
            wr_ptr_d   = rd_ptr_d;
            fill_ptr_d = rd_ptr_d;
        end else if (alloc) begin
            pc_d = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset: pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (alloc) begin
            buf_pc_q[wr_idx] <= pc_q;
        end
        if (fill_rsp) begin
            buf_instr_q[fill_idx] <= f_imem_rdata_i;
        end
    end

    assign f_valid_o = head_valid;
    assign f_instr_o = head_valid ? buf_instr_q[rd_idx] : NOP;
    assign f_pc_o    = head_valid ? buf_pc_q[rd_idx] : 64'd0;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        f_imem_req_o;
    logic [63:0] f_imem_addr_o;
    logic        f_imem_gnt_i;
    logic        f_imem_rvalid_i;
    logic [31:0] f_imem_rdata_i;
    logic        f_valid_o;
    logic        f_ready_i;
    logic [31:0] f_instr_o;
    logic [63:0] f_pc_o;
    logic        d_branch_i;
    logic [63:0] d_pc_b_i;
    logic        d_jump_jal_i;
    logic [63:0] d_pc_jal_i;
    logic        d_jump_jalr_i;
    logic [63:0] d_pc_jalr_i;

    ifetch #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .f_imem_req_o   (f_imem_req_o),
        .f_imem_addr_o  (f_imem_addr_o),
        .f_imem_gnt_i   (f_imem_gnt_i),
        .f_imem_rvalid_i(f_imem_rvalid_i),
        .f_imem_rdata_i (f_imem_rdata_i),
        .f_valid_o      (f_valid_o),
        .f_ready_i      (f_ready_i),
        .f_instr_o      (f_instr_o),
        .f_pc_o         (f_pc_o),
        .d_branch_i     (d_branch_i),
        .d_pc_b_i       (d_pc_b_i),
        .d_jump_jal_i   (d_jump_jal_i),
        .d_pc_jal_i     (d_pc_jal_i),
        .d_jump_jalr_i  (d_jump_jalr_i),
        .d_pc_jalr_i    (d_pc_jalr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Memory: in-order queue of granted addresses with their response cycle.
    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];

    int cyc = 0;
    int lat_lo = 1, lat_hi = 1;
    bit gnt_rand = 0;

    // Reference model: the architectural stream decode must see and the
    // address stream the fetcher must issue.
    logic [63:0] exp_pc = RESET_PC;
    logic [63:0] exp_fetch = RESET_PC;
    bit post_rst = 0;
    bit after_redir = 0;

    // Per-step observations for directed tests.
    bit          hs;
    logic [63:0] hs_pc;
    int          gnt_cnt = 0;
    int          hs_total = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC3C3_0003;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step();
        logic        s_req, s_valid, redir, s_gnt, s_rv;
        logic [63:0] s_addr, s_pc, tgt;
        logic [31:0] s_instr;
        int          prev_due, due;

        s_rv = !rst && memq.size() > 0 && memq[0].due <= cyc;
        f_imem_rvalid_i = s_rv;
        f_imem_rdata_i  = s_rv ? instr_of(memq[0].addr) : $urandom;
        f_imem_gnt_i    = 1'b0;
        #1;
        s_req   = f_imem_req_o;
        s_addr  = f_imem_addr_o;
        s_valid = f_valid_o;
        s_pc    = f_pc_o;
        s_instr = f_instr_o;
        s_gnt   = s_req && (!gnt_rand || $urandom_range(0, 2) != 0);
        f_imem_gnt_i = s_gnt;
        #1;
        hs = 0;

        if (rst) begin
            chk("req_in_reset", 64'(s_req), 64'd0);
            memq.delete();
            exp_pc      = RESET_PC;
            exp_fetch   = RESET_PC;
            post_rst    = 1;
            after_redir = 0;
        end else begin
            if (post_rst) begin
                chk("valid_after_reset", 64'(s_valid), 64'd0);
                chk("addr_after_reset", s_addr, RESET_PC);
                post_rst = 0;
            end
            if (after_redir) chk("valid_after_redirect", 64'(s_valid), 64'd0);
            if (!s_valid) begin
                chk("idle_instr_nop", 64'(s_instr), 64'(NOP));
                chk("idle_pc_zero", s_pc, 64'd0);
            end

            tgt = d_jump_jalr_i ? d_pc_jalr_i : d_jump_jal_i ? d_pc_jal_i : d_pc_b_i;
            tgt[1:0] = 2'b00;
            redir = s_valid && f_ready_i && (d_branch_i || d_jump_jal_i || d_jump_jalr_i);

            if (s_valid && f_ready_i) begin
                chk("handshake_pc", s_pc, exp_pc);
                chk("handshake_instr", 64'(s_instr), 64'(instr_of(exp_pc)));
                hs = 1;
                hs_pc = s_pc;
                hs_total++;
                exp_pc = redir ? tgt : exp_pc + 64'd4;
            end
            if (s_req) begin
                chk("fetch_addr", s_addr, exp_fetch);
                chk("req_within_credit", 64'(memq.size() < DEPTH), 64'd1);
            end
            if (redir) chk("no_req_on_redirect", 64'(s_req), 64'd0);

            if (redir) exp_fetch = tgt;
            else if (s_gnt) exp_fetch = exp_fetch + 64'd4;
            after_redir = redir;

            if (s_rv) void'(memq.pop_front());
            if (s_gnt) begin
                gnt_cnt++;
                prev_due = memq.size() > 0 ? memq[$].due : 0;
                due = cyc + $urandom_range(lat_lo, lat_hi);
                if (due <= prev_due) due = prev_due + 1;
                memq.push_back('{addr: s_addr, due: due});
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_redirects();
        d_branch_i    = 0;
        d_jump_jal_i  = 0;
        d_jump_jalr_i = 0;
        d_pc_b_i      = '0;
        d_pc_jal_i    = '0;
        d_pc_jalr_i   = '0;
    endtask

    task automatic do_reset();
        clear_redirects();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // Runs sequentially from reset and takes a jal at pc 8000_0008.
    task automatic run_to_jal(output bit found);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            d_jump_jal_i = f_valid_o && f_pc_o == 64'h8000_0008;
            d_pc_jal_i   = 64'h8000_0100;
            found = d_jump_jal_i;
            step();
        end
        clear_redirects();
    endtask

    task automatic wait_hs(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = hs;
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        logic [63:0] pcs[$];
        int  first_hs;
        bit  ok;

        rst = 1;
        f_ready_i = 1;
        f_imem_gnt_i = 0;
        f_imem_rvalid_i = 0;
        f_imem_rdata_i = '0;
        clear_redirects();
        @(negedge clk);

        // Sequential fetch, single-cycle memory.
        do_reset();
        first_hs = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (hs) begin
                if (first_hs < 0) first_hs = i;
                pcs.push_back(hs_pc);
            end
        end
        chk("first_valid_latency", 64'(first_hs), 64'd2);
        if (pcs.size() >= 3) begin
            chk("seq_pc0", pcs[0], 64'h8000_0000);
            chk("seq_pc1", pcs[1], 64'h8000_0004);
            chk("seq_pc2", pcs[2], 64'h8000_0008);
        end else begin
            timeout("seq_three_instrs");
        end

        // Decode stalled: buffer fills to DEPTH and requests stop.
        do_reset();
        f_ready_i = 0;
        gnt_cnt = 0;
        for (int i = 0; i < 6; i++) step();
        chk("stall_grants", 64'(gnt_cnt), 64'(DEPTH));
        chk("stall_req_low", 64'(f_imem_req_o), 64'd0);
        chk("stall_head_pc", f_pc_o, 64'h8000_0000);
        f_ready_i = 1;
        wait_hs("stall_release", ok);
        if (ok) chk("release_first_pc", hs_pc, 64'h8000_0000);
        for (int i = 0; i < 10; i++) step();

        // jal with a response in flight.
        lat_lo = 3;
        lat_hi = 3;
        do_reset();
        run_to_jal(ok);
        if (!ok) timeout("jal_reach_pc8");
        chk("jal_valid_drops", 64'(f_valid_o), 64'd0);
        wait_hs("jal_target", ok);
        if (ok) chk("jal_target_pc", hs_pc, 64'h8000_0100);

        // jalr outranks branch; target low bits cleared.
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (f_valid_o) begin
                d_jump_jalr_i = 1;
                d_pc_jalr_i   = 64'h8000_0203;
                d_branch_i    = 1;
                d_pc_b_i      = 64'h8000_0500;
                ok = 1;
            end
            step();
            clear_redirects();
        end
        if (!ok) timeout("jalr_wait_valid");
        chk("jalr_fetch_addr", f_imem_addr_o, 64'h8000_0200);
        wait_hs("jalr_target", ok);
        if (ok) chk("jalr_target_pc", hs_pc, 64'h8000_0200);

        // Redirect with nothing valid is ignored.
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        d_branch_i = 1;
        d_pc_b_i   = 64'h8000_0400;
        step();
        clear_redirects();
        chk("ignored_redirect_addr", f_imem_addr_o, 64'h8000_0004);
        for (int i = 0; i < 6; i++) step();

        // Reset while wrong-path responses are still owed.
        lat_lo = 3;
        lat_hi = 3;
        do_reset();
        run_to_jal(ok);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("midrst_valid", 64'(f_valid_o), 64'd0);
        chk("midrst_addr", f_imem_addr_o, RESET_PC);
        for (int i = 0; i < 10; i++) step();

        // Randomised traffic.
        lat_lo = 1;
        lat_hi = 4;
        gnt_rand = 1;
        hs_total = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            f_ready_i = ($urandom_range(0, 3) != 0);
            clear_redirects();
            if ($urandom_range(0, 5) == 0) begin
                d_branch_i    = $urandom_range(0, 1);
                d_jump_jal_i  = $urandom_range(0, 1);
                d_jump_jalr_i = $urandom_range(0, 1);
                d_pc_b_i      = 64'h8000_0000 | 64'($urandom_range(0, 4095));
                d_pc_jal_i    = 64'h8000_0000 | 64'($urandom_range(0, 4095));
                d_pc_jalr_i   = 64'h8000_0000 | 64'($urandom_range(0, 4095));
            end
            step();
        end
        rst = 0;
        clear_redirects();
        chk("random_progress", 64'(hs_total > 150), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
